// File: rtl/gb_fb_pkg.sv
// gb_fb_pkg: shared types and constants for the frame-buffer writer.
//   ppu_mode_t  : PPU mode encoding (same encoding the PPU drives on PPU_MODE)
//   wr_state_t  : writer sequencing state
//   fb_entry_t  : one queued frame-buffer write, {addr, data}
//   BYTES_PER_LINE, FB_BYTES, FB_AW : frame-buffer geometry
package gb_fb_pkg;

   typedef enum logic [1:0] {
      H_BLANK = 2'd0,
      V_BLANK = 2'd1,
      SCAN    = 2'd2,
      DRAW    = 2'd3
   } ppu_mode_t;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } wr_state_t;

   localparam int BYTES_PER_LINE = 40;
   localparam int FB_BYTES       = 5760;
   // Byte address width that covers the whole buffer (13 bits).
   localparam int FB_AW          = $clog2(FB_BYTES);

   typedef struct packed {
      logic [FB_AW-1:0] addr;
      logic [7:0]       data;
   } fb_entry_t;

endpackage

// File: rtl/gb_fb_fifo.sv
// gb_fb_fifo: synchronous FIFO holding {addr, data} frame-buffer writes.
//   clk, rst : clock, synchronous active-high reset
//   push/din : enqueue din; ignored when full unless a pop happens the same cycle
//   pop      : dequeue head; ignored when empty
//   dout     : current head entry
//   full, empty, count : occupancy
// DEPTH must be a power of 2 (pointers wrap naturally), at least 2.
module gb_fb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 21
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         do_push;
   logic         do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count   = wptr - rptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO still lands when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/gb_frame_writer.sv
// gb_frame_writer: PPU pixel-stream sink that packs 2-bit shades four per
// byte and writes them into a 160x144 frame buffer through a valid/ready port.
//   clk, rst            : clock, synchronous active-high reset
//   PX_OUT, PX_valid    : pixel shade from the PPU and its qualifier
//   PPU_MODE            : 0=H_BLANK 1=V_BLANK 2=SCAN 3=DRAW
//   LCD_EN              : LCDC bit 7; a falling edge aborts the frame
//   BGP                 : palette, only used when GB_FB_PALETTE_EN is defined
//   FB_WR/FB_ADDR/FB_DATA/FB_READY : frame-buffer write port
//   FRAME_DONE          : one-cycle pulse when the frame's last byte is accepted
//   LINE_ERR, OVERFLOW  : sticky error flags, cleared only by rst
// Write handshake: FB_WR is valid, FB_READY is ready; a write is transferred
// on a cycle where both are 1, and FB_ADDR/FB_DATA hold while FB_WR=1 and
// FB_READY=0.
// Optional feature: define GB_FB_PALETTE_EN to remap each shade s through
// BGP[2s+1:2s] before packing; otherwise shades are packed raw.
// Writer state is visible on the internal signal `state`.
module gb_frame_writer
   import gb_fb_pkg::*;
#(
   parameter int FB_BASE    = 0,
   parameter int H_PIXELS   = 160,
   parameter int V_LINES    = 144,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       PX_OUT,
   input  logic             PX_valid,
   input  logic [1:0]       PPU_MODE,
   input  logic             LCD_EN,
   input  logic [7:0]       BGP,
   output logic             FB_WR,
   output logic [FB_AW-1:0] FB_ADDR,
   output logic [7:0]       FB_DATA,
   input  logic             FB_READY,
   output logic             FRAME_DONE,
   output logic             LINE_ERR,
   output logic             OVERFLOW
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] H_MAX  = 8'(H_PIXELS);
   localparam logic [7:0] V_LAST = 8'(V_LINES - 1);

   wr_state_t        state;
   wr_state_t        state_nx;
   ppu_mode_t        mode;
   ppu_mode_t        prev_mode;
   logic             prev_lcd;
   logic [7:0]       x;
   logic [7:0]       y;
   logic [5:0]       pack;
   logic [1:0]       pcnt;
   logic [1:0]       shade;
   logic             lcd_fall;
   logic             vsync_edge;
   logic             draw_px;
   logic             take_px;
   logic             line_end;
   logic             push_req;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [FB_AW-1:0] addr_calc;
   fb_entry_t        push_entry;
   fb_entry_t        head;

   assign mode = ppu_mode_t'(PPU_MODE);

`ifdef GB_FB_PALETTE_EN
   assign shade = BGP[{PX_OUT, 1'b0} +: 2];
`else
   logic unused_bgp;
   assign unused_bgp = ^BGP;
   assign shade      = PX_OUT;
`endif

   assign lcd_fall   = prev_lcd && !LCD_EN;
   assign vsync_edge = (prev_mode == V_BLANK) && (mode == SCAN) && LCD_EN;
   assign draw_px    = (state == ACTIVE) && PX_valid && (mode == DRAW) && !lcd_fall;
   // Pixels past the end of the line are dropped (and flagged below).
   assign take_px    = draw_px && (x < H_MAX);
   assign line_end   = (state == ACTIVE) && (prev_mode == DRAW) && (mode == H_BLANK)
                       && !lcd_fall;

   // x is the pixel's own column for a full byte and the line's pixel count
   // for a trailing partial byte; both give the right byte column as x/4.
   assign addr_calc = FB_AW'(FB_BASE) + FB_AW'(y) * FB_AW'(BYTES_PER_LINE)
                      + FB_AW'(x[7:2]);

   always_comb begin
      push_req        = 1'b0;
      push_entry.addr = addr_calc;
      push_entry.data = {shade, pack};
      if (take_px && pcnt == 2'd3) begin
         push_req = 1'b1;
      end else if (line_end && pcnt != 2'd0) begin
         // Unused high slots of pack are already zero.
         push_req        = 1'b1;
         push_entry.data = {2'b00, pack};
      end
   end

   always_comb begin
      state_nx   = state;
      FRAME_DONE = 1'b0;
      if (lcd_fall) begin
         state_nx = SYNC;
      end else begin
         case (state)
            SYNC:   if (vsync_edge) state_nx = ACTIVE;
            ACTIVE: if (mode == V_BLANK || (line_end && y == V_LAST)) state_nx = DRAIN;
            DRAIN: begin
               if (fifo_empty || (pop && fifo_count == CW'(1))) begin
                  FRAME_DONE = 1'b1;
                  state_nx   = SYNC;
               end
            end
            default: state_nx = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SYNC;
         prev_mode <= H_BLANK;
         prev_lcd  <= 1'b0;
         x         <= '0;
         y         <= '0;
         pack      <= '0;
         pcnt      <= '0;
         LINE_ERR  <= 1'b0;
         OVERFLOW  <= 1'b0;
      end else begin
         state     <= state_nx;
         prev_mode <= mode;
         prev_lcd  <= LCD_EN;
         if (lcd_fall || (state == SYNC && vsync_edge)) begin
            x    <= '0;
            y    <= '0;
            pack <= '0;
            pcnt <= '0;
         end else if (take_px) begin
            x <= x + 8'd1;
            if (pcnt == 2'd3) begin
               pack <= '0;
               pcnt <= '0;
            end else begin
               case (pcnt)
                  2'd0:    pack[1:0] <= shade;
                  2'd1:    pack[3:2] <= shade;
                  default: pack[5:4] <= shade;
               endcase
               pcnt <= pcnt + 2'd1;
            end
         end else if (line_end) begin
            x    <= '0;
            y    <= y + 8'd1;
            pack <= '0;
            pcnt <= '0;
         end
         if ((draw_px && !take_px) || (line_end && x != H_MAX)) LINE_ERR <= 1'b1;
         if (push_req && fifo_full && !pop) OVERFLOW <= 1'b1;
      end
   end

   gb_fb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(fb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign FB_WR   = !fifo_empty;
   assign pop     = FB_WR && FB_READY;
   // Head is forced to zero when idle so the port reads 0 out of reset.
   assign FB_ADDR = FB_WR ? head.addr : '0;
   assign FB_DATA = FB_WR ? head.data : '0;

endmodule

// File: tb/tb_gb_frame_writer.sv
// tb_gb_frame_writer: directed bench for gb_frame_writer.
// A negedge monitor compares every accepted write against the expected
// queue and checks that the write port holds while stalled.
module tb_gb_frame_writer;
   import gb_fb_pkg::*;

`ifdef GB_FB_PALETTE_EN
   localparam logic [7:0] FRAME1_BYTE = 8'h1B;
`else
   localparam logic [7:0] FRAME1_BYTE = 8'hE4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  PX_OUT = 2'd0;
   logic        PX_valid = 1'b0;
   logic [1:0]  PPU_MODE = H_BLANK;
   logic        LCD_EN = 1'b1;
   logic [7:0]  BGP = 8'hE4;
   logic        FB_WR;
   logic [12:0] FB_ADDR;
   logic [7:0]  FB_DATA;
   logic        FB_READY = 1'b1;
   logic        FRAME_DONE;
   logic        LINE_ERR;
   logic        OVERFLOW;

   gb_frame_writer dut (
      .clk        (clk),
      .rst        (rst),
      .PX_OUT     (PX_OUT),
      .PX_valid   (PX_valid),
      .PPU_MODE   (PPU_MODE),
      .LCD_EN     (LCD_EN),
      .BGP        (BGP),
      .FB_WR      (FB_WR),
      .FB_ADDR    (FB_ADDR),
      .FB_DATA    (FB_DATA),
      .FB_READY   (FB_READY),
      .FRAME_DONE (FRAME_DONE),
      .LINE_ERR   (LINE_ERR),
      .OVERFLOW   (OVERFLOW)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   logic [20:0] exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          wr_count = 0;
   int          fd_count = 0;
   bit          held_valid = 1'b0;
   logic [20:0] held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (held_valid) begin
         check("hold fb_wr", {31'd0, FB_WR}, 32'd1);
         check("hold addr/data", {11'd0, FB_ADDR, FB_DATA}, {11'd0, held});
      end
      held_valid = FB_WR && !FB_READY;
      held       = {FB_ADDR, FB_DATA};
      if (FB_WR && FB_READY) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected write: got addr %0d data %h expected none", FB_ADDR, FB_DATA);
         end else begin
            check("write addr/data", {11'd0, FB_ADDR, FB_DATA}, {11'd0, exp_q.pop_front()});
         end
      end
      if (FRAME_DONE === 1'b1) fd_count++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle(input logic [1:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         PPU_MODE = m;
         PX_valid = 1'b0;
      end
   endtask

   task automatic drive_px(input logic [1:0] s);
      tick();
      PPU_MODE = DRAW;
      PX_valid = 1'b1;
      PX_OUT   = s;
   endtask

   task automatic vsync();
      set_idle(V_BLANK, 2);
      set_idle(SCAN, 2);
   endtask

   // One PPU line: SCAN, npix DRAW pixels, then H_BLANK (the line end).
   task automatic drive_line(input int npix, input logic [1:0] shade, input bit use_mod);
      set_idle(SCAN, 2);
      for (int k = 0; k < npix; k++) drive_px(use_mod ? 2'(k % 4) : shade);
      set_idle(H_BLANK, 4);
   endtask

   task automatic expect_line(input int y, input int nbytes, input logic [7:0] d, input int skip);
      for (int i = 0; i < nbytes; i++)
         if (i != skip) exp_q.push_back({13'(y * 40 + i), d});
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      check({name, " drained"}, exp_q.size(), 0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int         npix;
      logic [1:0] shade;
      logic [7:0] exp_full;
      logic [7:0] exp_last;
      int         last_idx;
      logic       exp_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int wr_before;
      int fd_before;
      int y;

      vecs[0] = '{160, 2'd1, 8'h55, 8'h55, 39, 1'b0};
      vecs[1] = '{160, 2'd2, 8'hAA, 8'hAA, 39, 1'b0};
      vecs[2] = '{158, 2'd3, 8'hFF, 8'h0F, 39, 1'b1};
      vecs[3] = '{157, 2'd2, 8'hAA, 8'h02, 39, 1'b1};
      vecs[4] = '{161, 2'd1, 8'h55, 8'h55, 39, 1'b1};
      vecs[5] = '{5,   2'd3, 8'hFF, 8'h03, 1,  1'b1};

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      check("reset fb_wr", FB_WR, 0);
      check("reset fb_addr", FB_ADDR, 0);
      check("reset fb_data", FB_DATA, 0);
      check("reset frame_done", FRAME_DONE, 0);
      check("reset line_err", LINE_ERR, 0);
      check("reset overflow", OVERFLOW, 0);

      // Pixels before any V_BLANK->SCAN edge are discarded
      for (int k = 0; k < 24; k++) drive_px(2'(k % 4));
      set_idle(H_BLANK, 4);
      check("presync writes", wr_count, 0);
      check("presync fb_wr", FB_WR, 0);

      // Frame 1: full 160x144 frame, shade pattern 0,1,2,3
      BGP = 8'h1B;
      vsync();
      for (int ln = 0; ln < 144; ln++) begin
         expect_line(ln, 40, FRAME1_BYTE, -1);
         drive_line(160, 2'd0, 1'b1);
      end
      wait_drain("frame1");
      set_idle(V_BLANK, 3);
      check("frame1 writes", wr_count, 5760);
      check("frame1 frame_done", fd_count, 1);
      check("frame1 line_err", LINE_ERR, 0);
      check("frame1 overflow", OVERFLOW, 0);

      // Frame 2, line 0: first-byte latency and a 10-cycle stall mid-line
      BGP = 8'hE4;
      vsync();
      expect_line(0, 40, 8'hE4, -1);
      set_idle(SCAN, 2);
      for (int k = 0; k < 160; k++) begin
         drive_px(2'(k % 4));
         FB_READY = !(k >= 40 && k < 50);
         if (k == 3) check("fb_wr before 4th px", FB_WR, 0);
         if (k == 4) check("fb_wr 1 cycle after 4th px", FB_WR, 1);
      end
      FB_READY = 1'b1;
      set_idle(H_BLANK, 4);
      wait_drain("stall line");
      check("stall overflow", OVERFLOW, 0);

      // Frame 2, line 1: FIFO fills, 5th byte is dropped
      expect_line(1, 40, 8'hE4, 4);
      set_idle(SCAN, 2);
      for (int k = 0; k < 160; k++) begin
         drive_px(2'(k % 4));
         FB_READY = (k >= 20);
         if (k == 19) check("overflow before 5th push", OVERFLOW, 0);
         if (k == 20) check("overflow at 5th push", OVERFLOW, 1);
      end
      set_idle(H_BLANK, 4);
      wait_drain("overflow line");
      check("overflow line_err", LINE_ERR, 0);

      // Frame 2, lines 2..7: table of line shapes
      y = 2;
      foreach (vecs[i]) begin
         expect_line(y, vecs[i].last_idx, vecs[i].exp_full, -1);
         exp_q.push_back({13'(y * 40 + vecs[i].last_idx), vecs[i].exp_last});
         drive_line(vecs[i].npix, vecs[i].shade, 1'b0);
         wait_drain($sformatf("vec%0d", i));
         check($sformatf("vec%0d line_err", i), LINE_ERR, vecs[i].exp_err);
         y++;
      end
      fd_before = fd_count;
      set_idle(V_BLANK, 4);
      check("frame2 frame_done", fd_count, fd_before + 1);

      // Frame 3: reset in the middle of line 70
      vsync();
      for (int ln = 0; ln < 70; ln++) begin
         expect_line(ln, 40, 8'hE4, -1);
         drive_line(160, 2'd0, 1'b1);
      end
      expect_line(70, 12, 8'hE4, -1);
      set_idle(SCAN, 2);
      for (int k = 0; k < 50; k++) drive_px(2'(k % 4));
      check("pre-reset queue", exp_q.size(), 0);
      check("sticky line_err", LINE_ERR, 1);
      check("sticky overflow", OVERFLOW, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst fb_wr", FB_WR, 0);
      check("mid rst fb_addr", FB_ADDR, 0);
      check("mid rst fb_data", FB_DATA, 0);
      check("mid rst frame_done", FRAME_DONE, 0);
      check("mid rst line_err", LINE_ERR, 0);
      check("mid rst overflow", OVERFLOW, 0);
      wr_before = wr_count;
      for (int k = 0; k < 30; k++) drive_px(2'(k % 4));
      set_idle(H_BLANK, 4);
      check("no write before resync", wr_count, wr_before);

      // Resume after a fresh V_BLANK->SCAN edge
      vsync();
      expect_line(0, 2, 8'hE4, -1);
      drive_line(8, 2'd0, 1'b1);
      wait_drain("resume line");

      // LCD_EN falls mid-line: pending byte drains, partial is discarded
      exp_q.push_back({13'd40, 8'hFF});
      set_idle(SCAN, 2);
      for (int k = 0; k < 6; k++) drive_px(2'd3);
      tick();
      LCD_EN   = 1'b0;
      PX_valid = 1'b0;
      PPU_MODE = H_BLANK;
      set_idle(H_BLANK, 3);
      LCD_EN = 1'b1;
      wait_drain("lcd off");
      vsync();
      exp_q.push_back({13'd0, 8'h55});
      drive_line(4, 2'd1, 1'b0);
      wait_drain("after lcd on");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
